// File: rtl/ehl_generic2apb.sv
// APB initiator: turns a single-outstanding generic register request into one
// APB transfer, returning read data, slave error and a wait-state timeout flag.
module ehl_generic2apb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADR_WIDTH  = 6,
    parameter int TIMEOUT    = 16
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  req,
    input  logic                  we,
    input  logic [ADR_WIDTH-1:0]  adr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  ready,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  err,
    output logic                  tout,
    output logic [ADR_WIDTH-1:0]  paddr,
    output logic                  pwrite,
    output logic                  psel,
    output logic                  penable,
    output logic [DATA_WIDTH-1:0] pwdata,
    input  logic                  pready,
    input  logic                  pslverr,
    input  logic [DATA_WIDTH-1:0] prdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam logic [16:0] LIMIT = 17'(TIMEOUT);

    state_t                  state, state_d;
    logic [15:0]             wait_cnt, wait_cnt_d;
    logic [16:0]             wait_next;
    logic                    limit_hit;
    logic                    done_d, err_d, tout_d, pwrite_d;
    logic [DATA_WIDTH-1:0]   rdata_d, pwdata_d;
    logic [ADR_WIDTH-1:0]    paddr_d;

    // The count includes the current stalled cycle, so TIMEOUT=N aborts on the N-th stall.
    assign wait_next = {1'b0, wait_cnt} + 17'd1;
    assign limit_hit = (TIMEOUT != 0) && (wait_next >= LIMIT);

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        done_d     = 1'b0;
        err_d      = err;
        tout_d     = tout;
        rdata_d    = rdata;
        paddr_d    = paddr;
        pwrite_d   = pwrite;
        pwdata_d   = pwdata;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_d    = SETUP;
                    wait_cnt_d = '0;
                    paddr_d    = adr;
                    pwrite_d   = we;
                    pwdata_d   = wdata;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                if (pready) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    err_d   = pslverr;
                    tout_d  = 1'b0;
                    if (!pwrite) rdata_d = prdata;
                end else begin
                    wait_cnt_d = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_next[15:0];
                    if (limit_hit) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        tout_d  = 1'b1;
                        if (!pwrite) rdata_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ready    <= 1'b1;
            done     <= 1'b0;
            rdata    <= '0;
            err      <= 1'b0;
            tout     <= 1'b0;
            paddr    <= '0;
            pwrite   <= 1'b0;
            psel     <= 1'b0;
            penable  <= 1'b0;
            pwdata   <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
            ready    <= (state_d == IDLE);
            done     <= done_d;
            rdata    <= rdata_d;
            err      <= err_d;
            tout     <= tout_d;
            paddr    <= paddr_d;
            pwrite   <= pwrite_d;
            psel     <= (state_d != IDLE);
            penable  <= (state_d == ACCESS);
            pwdata   <= pwdata_d;
        end
    end

endmodule

// File: tb/tb_ehl_generic2apb.sv
// Bench for ehl_generic2apb: a cycle-indexed timeline of expected outputs is
// filled in as each request is issued and compared on every falling edge.
module tb_ehl_generic2apb;

    localparam int TMO = 4;
    localparam int NC  = 4096;

    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        req = 1'b0, we = 1'b0;
    logic [5:0]  adr = '0;
    logic [31:0] wdata = '0;
    logic        ready, done, err, tout, pwrite, psel, penable;
    logic [31:0] rdata, pwdata;
    logic [5:0]  paddr;
    logic        pready = 1'b0, pslverr = 1'b0;
    logic [31:0] prdata = '0;

    ehl_generic2apb #(.DATA_WIDTH(32), .ADR_WIDTH(6), .TIMEOUT(TMO)) dut (
        .pclk(pclk), .presetn(presetn), .req(req), .we(we), .adr(adr), .wdata(wdata),
        .ready(ready), .done(done), .rdata(rdata), .err(err), .tout(tout),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
        .pready(pready), .pslverr(pslverr), .prdata(prdata)
    );

    always #5 pclk = ~pclk;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    int total = 0, bad = 0;
    int last_acc = 0;

    // Expected timeline, indexed by cycle number.
    bit          e_busy[NC], e_psel[NC], e_pen[NC], e_done[NC];
    bit          r_v[NC], r_err[NC], r_tout[NC], rd_v[NC], a_v[NC], a_we[NC];
    logic [31:0] rd_val[NC], a_wd[NC];
    logic [5:0]  a_adr[NC];

    // Held outputs as the model sees them.
    logic [31:0] m_rdata, m_wd;
    logic [5:0]  m_adr;
    logic        m_err, m_tout, m_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    always @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            m_rdata <= '0; m_err <= 1'b0; m_tout <= 1'b0;
            m_adr <= '0; m_we <= 1'b0; m_wd <= '0;
        end else if (cyc + 1 < NC) begin
            if (r_v[cyc+1]) begin
                m_err  <= r_err[cyc+1];
                m_tout <= r_tout[cyc+1];
            end
            if (rd_v[cyc+1]) m_rdata <= rd_val[cyc+1];
            if (a_v[cyc+1]) begin
                m_adr <= a_adr[cyc+1];
                m_we  <= a_we[cyc+1];
                m_wd  <= a_wd[cyc+1];
            end
        end
    end

    always @(negedge pclk) begin
        if (cyc < NC) begin
            chk("ready",   32'(ready),   32'(!e_busy[cyc]));
            chk("psel",    32'(psel),    32'(e_psel[cyc]));
            chk("penable", 32'(penable), 32'(e_pen[cyc]));
            chk("done",    32'(done),    32'(e_done[cyc]));
            chk("rdata",   rdata,        m_rdata);
            chk("err",     32'(err),     32'(m_err));
            chk("tout",    32'(tout),    32'(m_tout));
            chk("paddr",   32'(paddr),   32'(m_adr));
            chk("pwrite",  32'(pwrite),  32'(m_we));
            chk("pwdata",  pwdata,       m_wd);
        end
    end

    always @(posedge pclk) begin
        if (cyc >= NC - 8) begin
            $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
            $fatal(1, "cycle budget exhausted");
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            req = 1'b0; we = 1'($urandom); adr = 6'($urandom); wdata = $urandom;
            pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            @(posedge pclk); #1;
        end
    endtask

    // Issue one request in the current (idle) cycle and play the slave side.
    task automatic xfer(input bit w, input logic [5:0] a, input logic [31:0] d, input int waits,
                        input bit slv, input logic [31:0] rv, input bit ign, input int rst_rel);
        int acc, endr;
        bit tm;
        acc = cyc;
        last_acc = cyc;
        tm = (TMO != 0) && (waits >= TMO);
        endr = tm ? 2 + TMO : 3 + waits;
        for (int r = 1; r < endr; r++) begin
            e_busy[acc+r] = 1'b1;
            e_psel[acc+r] = 1'b1;
            e_pen[acc+r]  = (r >= 2);
        end
        e_done[acc+endr] = 1'b1;
        r_v[acc+endr]    = 1'b1;
        r_err[acc+endr]  = tm | slv;
        r_tout[acc+endr] = tm;
        rd_v[acc+endr]   = !w;
        rd_val[acc+endr] = tm ? 32'h0 : rv;
        a_v[acc+1] = 1'b1; a_we[acc+1] = w; a_adr[acc+1] = a; a_wd[acc+1] = d;

        req = 1'b1; we = w; adr = a; wdata = d;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        @(posedge pclk); #1;
        req = ign ? 1'($urandom) : 1'b0;
        we = 1'($urandom); adr = 6'($urandom); wdata = $urandom;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
        @(posedge pclk); #1;
        for (int r = 2; r < endr; r++) begin
            if (rst_rel == r) begin
                presetn = 1'b0;
                for (int c = cyc; c < NC; c++) begin
                    e_busy[c] = 0; e_psel[c] = 0; e_pen[c] = 0; e_done[c] = 0;
                    r_v[c] = 0; rd_v[c] = 0; a_v[c] = 0;
                end
                #1;
                chk("rst_psel",    32'(psel),    32'd0);
                chk("rst_penable", 32'(penable), 32'd0);
                chk("rst_done",    32'(done),    32'd0);
                chk("rst_ready",   32'(ready),   32'd1);
                @(posedge pclk); #1;
                presetn = 1'b1;
                req = 1'b0;
                return;
            end
            req = ign ? 1'($urandom) : 1'b0;
            we = 1'($urandom); adr = 6'($urandom); wdata = $urandom;
            if (r - 2 < waits) begin
                pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
            end else begin
                pready = 1'b1; pslverr = slv; prdata = rv;
            end
            @(posedge pclk); #1;
        end
        req = 1'b0;
        pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
    endtask

    initial begin
        int a1;
        presetn = 1'b0;
        @(posedge pclk); #1;
        @(posedge pclk); #1;
        chk("reset_ready", 32'(ready), 32'd1);
        chk("reset_psel",  32'(psel),  32'd0);
        presetn = 1'b1;
        idle(3);

        xfer(1'b1, 6'h04, 32'hA5A5_0001, 0, 1'b0, 32'h0, 1'b0, 0);
        chk("wr0_latency", cyc - last_acc, 32'd3);
        chk("wr0_done",    32'(done),      32'd1);
        chk("wr0_err",     32'(err),       32'd0);
        chk("wr0_paddr",   32'(paddr),     32'h04);
        idle(2);

        xfer(1'b0, 6'h10, 32'h0, 3, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);
        chk("rd3_latency", cyc - last_acc, 32'd6);
        chk("rd3_rdata",   rdata,          32'hDEAD_BEEF);
        chk("rd3_err",     32'(err),       32'd0);
        chk("rd3_tout",    32'(tout),      32'd0);
        idle(1);

        xfer(1'b0, 6'h21, 32'h0, 2, 1'b1, 32'h1234_5678, 1'b0, 0);
        chk("slv_err",   32'(err),  32'd1);
        chk("slv_tout",  32'(tout), 32'd0);
        chk("slv_rdata", rdata,     32'h1234_5678);
        idle(1);

        xfer(1'b0, 6'h22, 32'h0, 9, 1'b0, 32'hFFFF_FFFF, 1'b0, 0);
        chk("to_latency", cyc - last_acc, 32'd6);
        chk("to_done",    32'(done),      32'd1);
        chk("to_err",     32'(err),       32'd1);
        chk("to_tout",    32'(tout),      32'd1);
        chk("to_rdata",   rdata,          32'h0);
        chk("to_psel",    32'(psel),      32'd0);

        xfer(1'b1, 6'h05, 32'h0000_00C3, 1, 1'b0, 32'h0, 1'b0, 0);
        chk("after_to_tout", 32'(tout), 32'd0);
        chk("after_to_err",  32'(err),  32'd0);

        xfer(1'b1, 6'h06, 32'h1111_0000, 0, 1'b0, 32'h0, 1'b0, 0);
        a1 = last_acc;
        xfer(1'b1, 6'h07, 32'h2222_0000, 0, 1'b0, 32'h0, 1'b1, 0);
        chk("b2b_spacing", last_acc - a1, 32'd3);
        idle(2);

        xfer(1'b0, 6'h30, 32'h0, 3, 1'b0, 32'h5555_AAAA, 1'b0, 3);
        idle(1);
        chk("post_rst_ready", 32'(ready), 32'd1);
        xfer(1'b0, 6'h31, 32'h0, 0, 1'b0, 32'h0BAD_F00D, 1'b0, 0);
        chk("post_rst_done",  32'(done), 32'd1);
        chk("post_rst_rdata", rdata,     32'h0BAD_F00D);

        for (int n = 0; n < 200 && cyc < NC - 100; n++) begin
            int wt;
            wt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(TMO, TMO + 3)) : int'($urandom_range(0, TMO - 1));
            xfer(1'($urandom), 6'($urandom), $urandom, wt, ($urandom_range(0, 3) == 0),
                 $urandom, 1'($urandom), 0);
            idle(int'($urandom_range(0, 2)));
        end

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
